// File: rtl/fas_pkg.sv
// ============================================================
// fas_pkg : shared FFT point/frame types and magnitude helper
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

package fas_pkg;
    localparam int DW  = 16;
    localparam int NPT = 16;
    localparam int MW  = DW + 1;
    localparam int IW  = 4;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } point_t;

    typedef point_t [NPT-1:0] frame_t;

    // |re| + |im| in MW bits; |-32768| = 32768 fits without saturation.
    function automatic logic [MW-1:0] abs_sum(input point_t p);
        logic [MW-1:0] w_re;
        logic [MW-1:0] w_im;
        w_re = {p.re[DW-1], p.re};
        w_im = {p.im[DW-1], p.im};
        if (w_re[MW-1]) w_re = -w_re;
        if (w_im[MW-1]) w_im = -w_im;
        return w_re + w_im;
    endfunction
endpackage

`default_nettype wire

// File: rtl/fft_peak_tracker.sv
// ============================================================
// fft_peak_tracker : running max/argmax of beat magnitudes
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module fft_peak_tracker
    import fas_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_clear,
    input  logic [MW-1:0] i_mag,
    input  logic [IW-1:0] i_idx,
    output logic [IW-1:0] o_peak
);
    logic [MW-1:0] r_max;
    logic [IW-1:0] r_peak;
    logic          w_gt;

    // Strict compare keeps the lower index on ties.
    assign w_gt   = i_mag > r_max;
    assign o_peak = w_gt ? i_idx : r_peak;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max  <= '0;
            r_peak <= '0;
        end else if (i_clear) begin
            r_max  <= '0;
            r_peak <= '0;
        end else if (i_en && w_gt) begin
            r_max  <= i_mag;
            r_peak <= i_idx;
        end
    end
endmodule

`default_nettype wire

// File: rtl/fft_frame_serializer.sv
// ============================================================
// fft_frame_serializer : ping-pong buffered 16-point frame to beat stream
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module fft_frame_serializer #(
    parameter int DW   = 16,
    parameter int NPT  = 16,
    parameter int CNTW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fft_valid,
    input  logic [NPT*2*DW-1:0] fft_frame,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DW-1:0]     out_data,
    output logic [3:0]          out_index,
    output logic                out_last,
    output logic [3:0]          out_peak,
    output logic [CNTW-1:0]     drop_cnt,
    output logic                overflow
);
    import fas_pkg::*;

    frame_t          r_buf [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic [IW-1:0]   r_idx;
    logic [CNTW-1:0] r_drop_cnt;
    logic            r_overflow;

    point_t          w_cur;
    logic [MW-1:0]   w_mag;
    logic            w_is_last;
    logic            w_hs;
    logic            w_release;
    logic            w_accept;
    logic [IW-1:0]   w_peak;

    assign w_cur     = r_buf[r_rd_ptr][r_idx];
    assign w_mag     = abs_sum(w_cur);
    assign w_is_last = (r_idx == IW'(NPT-1));
    assign out_valid = (r_count != 2'd0);
    assign w_hs      = out_valid & out_ready;
    assign w_release = w_hs & w_is_last;
    // A full pair may still accept when its oldest frame leaves on this edge.
    assign w_accept  = fft_valid & ((r_count != 2'd2) | w_release);

    assign out_data  = out_valid ? w_cur : '0;
    assign out_index = r_idx;
    assign out_last  = out_valid & w_is_last;
    assign out_peak  = out_last ? w_peak : '0;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

    fft_peak_tracker u_peak (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_hs & ~w_is_last),
        .i_clear (w_release),
        .i_mag   (w_mag),
        .i_idx   (r_idx),
        .o_peak  (w_peak)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_idx      <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= fft_valid & ~w_accept;
            if (fft_valid && !w_accept && !(&r_drop_cnt))
                r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_accept)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_hs) begin
                r_idx <= w_is_last ? '0 : r_idx + 1'b1;
                if (w_is_last)
                    r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_release})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame storage carries no reset; its contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_buf[r_wr_ptr] <= fft_frame;
    end
endmodule

`default_nettype wire
